i2c_write_model: RTL and testbench

//  Testbench bit-bang I2C byte writer and upstream partner of the I2C read model.
//  On START it shifts one byte MSB-first onto SDA with a generated SCLK.
//  It then releases SDA for a 9th clock, samples the slave ACK and pulses DONE.
//  The bench sequencer uses it to send the slave address/register bytes before launching a read.

---
 rtl/i2c_write_model_if.sv | 26 ++
 rtl/i2c_write_model.sv | 166 ++++++++++++++++
 tb/tb_i2c_write_model.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_write_model_if.sv
// Bus bundle for the bit-bang I2C byte writer. The master modport is the writer itself;
// the slave modport is the sequencer/slave side that requests bytes and answers ACK.
`timescale 1ns / 1ps

interface i2c_write_model_if;
  logic       START;
  logic [7:0] DIN;
  logic       SDA_IN;
  logic       SCL_IN;
  logic       SCLK;
  logic       SDA_OUT;
  logic       SDA_OE;
  logic       DONE;
  logic       ACK_ERR;
  logic       PERFORM_WRITE;

  modport master (
    input  START, DIN, SDA_IN, SCL_IN,
    output SCLK, SDA_OUT, SDA_OE, DONE, ACK_ERR, PERFORM_WRITE
  );

  modport slave (
    output START, DIN, SDA_IN, SCL_IN,
    input  SCLK, SDA_OUT, SDA_OE, DONE, ACK_ERR, PERFORM_WRITE
  );
endinterface

// File: rtl/i2c_write_model.sv
// Bit-bang I2C byte writer: on START shifts DIN out MSB-first with a generated SCLK, releases
// SDA for a 9th clock to sample the slave ACK, then pulses DONE.
// Optional feature macro: I2C_WR_STRETCH_EN enables slave clock stretching via SCL_IN during
// the SCLK-high phases. Without it SCL_IN is ignored.
`timescale 1ns / 1ps

module i2c_write_model #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input logic               CLK,
  input logic               RST_N,
  i2c_write_model_if.master bus
);

  localparam logic [7:0] HalfLast = 8'(HALF_PERIOD - 1);

  typedef enum logic [6:0] {
    StIdle   = 7'b000_0001,
    StLoad   = 7'b000_0010,
    StDataLo = 7'b000_0100,
    StDataHi = 7'b000_1000,
    StAckLo  = 7'b001_0000,
    StAckHi  = 7'b010_0000,
    StWrDone = 7'b100_0000
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] half_cnt_q, half_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_err_q, ack_err_d;
  logic       sclk_q, sclk_d;
  logic       sda_out_q, sda_out_d;
  logic       sda_oe_q, sda_oe_d;
  logic       done_q, done_d;
  logic       perform_write_q, perform_write_d;

  logic half_done;
  logic hold;

  assign half_done = (half_cnt_q == HalfLast);

`ifdef I2C_WR_STRETCH_EN
  // A slave holding SCL low freezes the high-phase timer until it lets go.
  assign hold = ((state_q == StDataHi) || (state_q == StAckHi)) && !bus.SCL_IN;
`else
  logic unused_scl_in;
  assign unused_scl_in = bus.SCL_IN;
  assign hold          = 1'b0;
`endif

  // State, counters and data registers; async reset releases the bus at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q         <= StIdle;
      half_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      ack_err_q       <= 1'b0;
      sclk_q          <= 1'b0;
      sda_out_q       <= 1'b0;
      sda_oe_q        <= 1'b0;
      done_q          <= 1'b0;
      perform_write_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      half_cnt_q      <= half_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      ack_err_q       <= ack_err_d;
      sclk_q          <= sclk_d;
      sda_out_q       <= sda_out_d;
      sda_oe_q        <= sda_oe_d;
      done_q          <= done_d;
      perform_write_q <= perform_write_d;
    end
  end

  // Next-state, half-period timer, bit counter, shifter and ACK capture.
  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ack_err_d  = ack_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.START) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        shift_d    = bus.DIN;
        bit_cnt_d  = '0;
        half_cnt_d = '0;
        ack_err_d  = 1'b0;
        state_d    = StDataLo;
      end
      StDataLo: begin
        if (half_done) begin
          half_cnt_d = '0;
          state_d    = StDataHi;
        end else begin
          half_cnt_d = half_cnt_q + 8'd1;
        end
      end
      StDataHi: begin
        if (!hold) begin
          if (half_done) begin
            half_cnt_d = '0;
            shift_d    = {shift_q[6:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            state_d    = (bit_cnt_q == 3'd7) ? StAckLo : StDataLo;
          end else begin
            half_cnt_d = half_cnt_q + 8'd1;
          end
        end
      end
      StAckLo: begin
        if (half_done) begin
          half_cnt_d = '0;
          state_d    = StAckHi;
        end else begin
          half_cnt_d = half_cnt_q + 8'd1;
        end
      end
      StAckHi: begin
        if (!hold) begin
          if (half_done) begin
            half_cnt_d = '0;
            ack_err_d  = bus.SDA_IN;
            state_d    = StWrDone;
          end else begin
            half_cnt_d = half_cnt_q + 8'd1;
          end
        end
      end
      StWrDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        half_cnt_d = '0;
      end
    endcase
  end

  // Bus outputs decoded from the current state, registered so they trail it by one CLK.
  always_comb begin
    sclk_d          = (state_q == StDataHi) || (state_q == StAckHi);
    sda_oe_d        = (state_q == StDataLo) || (state_q == StDataHi);
    // Data only updates in the low phase, so it is stable across the whole high phase.
    sda_out_d       = (state_q == StDataLo) ? shift_q[7] : sda_out_q;
    done_d          = (state_q == StWrDone);
    perform_write_d = (state_q != StIdle);
  end

  assign bus.SCLK          = sclk_q;
  assign bus.SDA_OUT       = sda_out_q;
  assign bus.SDA_OE        = sda_oe_q;
  assign bus.DONE          = done_q;
  assign bus.ACK_ERR       = ack_err_q;
  assign bus.PERFORM_WRITE = perform_write_q;

endmodule

// File: tb/tb_i2c_write_model.sv
// Scoreboard bench for i2c_write_model: drivers push the expected byte, ACK result and DONE
// cycle; per-instance monitors rebuild the byte from SDA at SCLK rises and check on DONE.
`timescale 1ns / 1ps

module tb_i2c_write_model;

  localparam int Hp0 = 2;
  localparam int Hp1 = 1;

  typedef struct {
    logic [7:0] data;
    logic       ack_err;
    int         done_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   exp_stretch0;
  exp_t q0[$];
  exp_t q1[$];

  i2c_write_model_if bus0 ();
  i2c_write_model_if bus1 ();

  i2c_write_model #(.HALF_PERIOD(Hp0)) u_dut0 (.CLK(clk), .RST_N(rst_n), .bus(bus0));
  i2c_write_model #(.HALF_PERIOD(Hp1)) u_dut1 (.CLK(clk), .RST_N(rst_n), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges; read only on falling edges.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor for the HALF_PERIOD=2 instance.
  int         rises0;
  int         last_rise0;
  logic       prev0;
  logic [7:0] cap0;
  exp_t       e0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rises0 = 0;
      prev0  = 1'b0;
      cap0   = '0;
    end else begin
      if (bus0.SCLK && !prev0) begin
        if (rises0 > 0) begin
          chk("sclk_period0", cyc - last_rise0, 2 * Hp0 + ((rises0 == 1) ? exp_stretch0 : 0));
        end
        if (rises0 < 8) begin
          cap0 = {cap0[6:0], bus0.SDA_OUT};
          chk("sda_oe_data0", int'(bus0.SDA_OE), 1);
        end else begin
          chk("sda_oe_ack0", int'(bus0.SDA_OE), 0);
        end
        rises0++;
        last_rise0 = cyc;
      end
      prev0 = bus0.SCLK;
      if (bus0.DONE) begin
        if (q0.size() == 0) begin
          chk("unexpected_done0", 1, 0);
        end else begin
          e0 = q0.pop_front();
          chk("data0", int'(cap0), int'(e0.data));
          chk("ack_err0", int'(bus0.ACK_ERR), int'(e0.ack_err));
          chk("sclk_pulses0", rises0, 9);
          chk("done_cycle0", cyc, e0.done_cyc);
        end
        rises0 = 0;
      end
    end
  end

  // Monitor for the HALF_PERIOD=1 instance.
  int         rises1;
  int         last_rise1;
  logic       prev1;
  logic [7:0] cap1;
  exp_t       e1;
  always @(negedge clk) begin
    if (!rst_n) begin
      rises1 = 0;
      prev1  = 1'b0;
      cap1   = '0;
    end else begin
      if (bus1.SCLK && !prev1) begin
        if (rises1 > 0) chk("sclk_period1", cyc - last_rise1, 2 * Hp1);
        if (rises1 < 8) cap1 = {cap1[6:0], bus1.SDA_OUT};
        rises1++;
        last_rise1 = cyc;
      end
      prev1 = bus1.SCLK;
      if (bus1.DONE) begin
        if (q1.size() == 0) begin
          chk("unexpected_done1", 1, 0);
        end else begin
          e1 = q1.pop_front();
          chk("data1", int'(cap1), int'(e1.data));
          chk("ack_err1", int'(bus1.ACK_ERR), int'(e1.ack_err));
          chk("sclk_pulses1", rises1, 9);
          chk("done_cycle1", cyc, e1.done_cyc);
        end
        rises1 = 0;
      end
    end
  end

  // One START pulse; DONE expected 18*HP+2 edges after the sampling edge (+ stretch).
  task automatic send0(input logic [7:0] din, input logic ack, input int extra);
    exp_t e;
    @(negedge clk);
    bus0.DIN    = din;
    bus0.SDA_IN = ack;
    e.data      = din;
    e.ack_err   = ack;
    e.done_cyc  = cyc + 1 + 18 * Hp0 + 2 + extra;
    q0.push_back(e);
    bus0.START = 1'b1;
    @(negedge clk);
    bus0.START = 1'b0;
  endtask

  task automatic wait_q0();
    for (int i = 0; i < 400 && q0.size() != 0; i++) @(negedge clk);
    chk("done0_arrived", q0.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    exp_t e;
    rst_n        = 1'b0;
    exp_stretch0 = 0;
    bus0.START = 1'b0; bus0.DIN = '0; bus0.SDA_IN = 1'b0; bus0.SCL_IN = 1'b1;
    bus1.START = 1'b0; bus1.DIN = '0; bus1.SDA_IN = 1'b0; bus1.SCL_IN = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sclk", int'(bus0.SCLK), 0);
    chk("rst_sda_out", int'(bus0.SDA_OUT), 0);
    chk("rst_sda_oe", int'(bus0.SDA_OE), 0);
    chk("rst_done", int'(bus0.DONE), 0);
    chk("rst_ack_err", int'(bus0.ACK_ERR), 0);
    chk("rst_perform_write", int'(bus0.PERFORM_WRITE), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 acked; DIN changed mid-byte must not matter.
    send0(8'hA5, 1'b0, 0);
    repeat (10) @(negedge clk);
    bus0.DIN = 8'hFF;
    wait_q0();
    chk("idle_after_a5", int'(bus0.PERFORM_WRITE), 0);

    // 0x3C NACKed: ACK_ERR stays set until the next LOAD.
    send0(8'h3C, 1'b1, 0);
    wait_q0();
    repeat (5) @(negedge clk);
    chk("ack_err_held", int'(bus0.ACK_ERR), 1);

    // 0xC3 acked; START pulsed mid-byte is ignored.
    send0(8'hC3, 1'b0, 0);
    chk("ack_err_before_load", int'(bus0.ACK_ERR), 1);
    @(negedge clk);
    chk("ack_err_cleared_load", int'(bus0.ACK_ERR), 0);
    repeat (12) @(negedge clk);
    bus0.START = 1'b1;
    @(negedge clk);
    bus0.START = 1'b0;
    wait_q0();
    repeat (40) @(negedge clk);
    chk("no_queued_start", int'(bus0.PERFORM_WRITE), 0);

    // Async reset during bit 4 high phase, then a full byte.
    send0(8'h5A, 1'b0, 0);
    for (int i = 0; i < 300 && rises0 < 5; i++) @(negedge clk);
    chk("reached_bit4", int'(rises0 >= 5), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sclk", int'(bus0.SCLK), 0);
    chk("midrst_sda_oe", int'(bus0.SDA_OE), 0);
    chk("midrst_perform_write", int'(bus0.PERFORM_WRITE), 0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send0(8'h81, 1'b0, 0);
    wait_q0();

`ifdef I2C_WR_STRETCH_EN
    // Slave holds SCL low for 5 cycles during bit 0 high phase.
    exp_stretch0 = 5;
    send0(8'h69, 1'b0, 5);
    repeat (3) @(negedge clk);
    bus0.SCL_IN = 1'b0;
    repeat (5) @(negedge clk);
    bus0.SCL_IN = 1'b1;
    wait_q0();
    exp_stretch0 = 0;
`endif

    // HALF_PERIOD=1 with START held: three back-to-back bytes, DONE every 21 cycles.
    @(negedge clk);
    k           = cyc + 1;
    bus1.DIN    = 8'h96;
    bus1.SDA_IN = 1'b0;
    bus1.START  = 1'b1;
    for (int n = 0; n < 3; n++) begin
      e.data     = 8'h96;
      e.ack_err  = 1'b0;
      e.done_cyc = k + 20 + 21 * n;
      q1.push_back(e);
    end
    while (cyc < k + 42) @(negedge clk);
    bus1.START = 1'b0;
    for (int i = 0; i < 200 && q1.size() != 0; i++) @(negedge clk);
    chk("done1_arrived", q1.size(), 0);
    repeat (30) @(negedge clk);
    chk("idle_after_b2b", int'(bus1.PERFORM_WRITE), 0);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
